riscv_fetch_queue: RTL

Parametrised instruction-fetch front end for the Riscv151 pipeline family. It replaces the single-register fetch stage. It owns the PC and issues one word per cycle to the synchronous icache, honouring the memory stall. Returned words are buffered in a DEPTH-entry queue with a valid/ready handshake toward decode. A redirect (branch/jump) flushes the queue and squashes any in-flight response.

---
 rtl/riscv_fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/riscv_fetch_queue.sv | 100 ++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared defaults, the queue entry layout and width helpers for the fetch front end.
package riscv_fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_2000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] inst;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;

  // Width needed to hold an entry count of 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; pointers wrap modulo DEPTH.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(fetch_entry_t),
  localparam int CNT_W = occ_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !full && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_fetch_queue.sv
// Fetch front end: owns the PC, issues one icache read per cycle under a credit
// limit, and buffers returned words for decode; redirects flush and squash.
module riscv_fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_DEF),
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEF),
  localparam int             OCC_W    = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [XLEN-1:0]  icache_addr,
  output logic             icache_re,
  input  logic [XLEN-1:0]  icache_dout,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_pc,
  output logic [OCC_W-1:0] occupancy
);

  localparam int EW = 2 * XLEN;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] target;
  logic            inflight;
  logic            drop;
  logic            accept;
  logic            respond;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  logic [EW-1:0]   head;

  assign target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign icache_addr = redirect_valid ? target : pc;

  // Credit: a request is only issued if its response is guaranteed a slot.
  assign icache_re = !reset && ((int'(occupancy) + int'(inflight)) < DEPTH);

  assign accept  = icache_re && !stall;
  assign respond = inflight && !stall;
  assign push    = respond && !drop && !redirect_valid;
  assign pop     = inst_valid && inst_ready;

  assign inst_valid = !empty;
  assign inst       = inst_valid ? head[EW-1:XLEN] : NOP_INST;
  assign inst_pc    = inst_valid ? head[XLEN-1:0]  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= PC_RESET;
      req_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (accept) begin
        pc     <= icache_addr + XLEN'(4);
        req_pc <= icache_addr;
      end else if (redirect_valid) begin
        pc <= target;
      end

      if (accept)       inflight <= 1'b1;
      else if (respond) inflight <= 1'b0;

      // A redirect during stall cannot squash the pending word at this edge,
      // so mark it to be discarded when it finally returns.
      if (redirect_valid && stall && inflight) drop <= 1'b1;
      else if (respond)                        drop <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data ({icache_dout, req_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (occupancy),
    .empty     (empty),
    .full      (full)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && full && !redirect_valid));

endmodule
